// File: rtl/cnn_conv_mac_ctrl_pkg.sv
// cnn_conv_mac_ctrl_pkg
// Shared definitions for the convolution MAC controller. This file has no ports.
// It provides:
//   - the operand, product and accumulator widths
//   - the controller state encoding
//   - a helper that sign-extends a product to the accumulator width
package cnn_conv_mac_ctrl_pkg;

  localparam int ACT_W  = 10;  // signed activation width
  localparam int WGT_W  = 14;  // signed weight width
  localparam int PROD_W = 25;  // signed product width (10s x 14s, with headroom)
  localparam int ACC_W  = 32;  // signed accumulator width
  localparam int ADDR_W = 4;   // tap address width (up to 16 taps)

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/cnn_conv_mac_ctrl_if.sv
// cnn_conv_mac_ctrl_if
// Groups every signal of the MAC controller except its clock and reset.
//   Block control : ap_start, ap_idle, ap_ready, ap_done, bias
//   Memory ports  : act_address0 / act_ce0 / act_q0 and w_address0 / w_ce0 / w_q0
//   Result stream : out_data, out_valid, out_ready
// Modports:
//   slave  - the controller itself
//   master - the host side, which issues starts and serves both memories
interface cnn_conv_mac_ctrl_if;
  import cnn_conv_mac_ctrl_pkg::*;

  logic                     ap_start;
  logic                     ap_idle;
  logic                     ap_ready;
  logic                     ap_done;
  logic signed [ACC_W-1:0]  bias;

  logic [ADDR_W-1:0]        act_address0;
  logic                     act_ce0;
  logic signed [ACT_W-1:0]  act_q0;

  logic [ADDR_W-1:0]        w_address0;
  logic                     w_ce0;
  logic signed [WGT_W-1:0]  w_q0;

  logic signed [ACC_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  ap_start, bias, act_q0, w_q0, out_ready,
    output ap_idle, ap_ready, ap_done,
           act_address0, act_ce0, w_address0, w_ce0,
           out_data, out_valid
  );

  modport master (
    output ap_start, bias, act_q0, w_q0, out_ready,
    input  ap_idle, ap_ready, ap_done,
           act_address0, act_ce0, w_address0, w_ce0,
           out_data, out_valid
  );

endinterface

// File: rtl/cnn_mac_mul_10s_14s.sv
// cnn_mac_mul_10s_14s
// Combinational signed multiplier: 10-bit signed times 14-bit signed gives a
// 25-bit signed product. The structure is kept plain so synthesis can map it
// onto a DSP slice.
//   a_i : activation operand
//   b_i : weight operand
//   p_o : product
module cnn_mac_mul_10s_14s
  import cnn_conv_mac_ctrl_pkg::*;
(
  input  logic signed [ACT_W-1:0]  a_i,
  input  logic signed [WGT_W-1:0]  b_i,
  output logic signed [PROD_W-1:0] p_o
);

  // Both operands are widened to the product width before multiplying, so
  // the full-precision result is kept.
  assign p_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/cnn_conv_mac_ctrl.sv
// cnn_conv_mac_ctrl
// Computes one dot product per start: acc = bias + sum(act[i] * w[i]) for
// i = 0 .. NTAPS-1. When RELU is enabled, a negative result is clamped to 0.
//   ap_clk : clock
//   ap_rst : asynchronous active-high reset
//   bus    : slave view of cnn_conv_mac_ctrl_if, which carries block control,
//            both memory read ports and the result handshake
// Timing: out_valid is first high NTAPS+3 cycles after the cycle in which the
// start is accepted.
module cnn_conv_mac_ctrl
  import cnn_conv_mac_ctrl_pkg::*;
#(
  parameter int NTAPS = 9,
  parameter int RELU  = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  cnn_conv_mac_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     s1_vld_q, s1_vld_d;   // read data present on *_q0 this cycle
  logic                     s2_vld_q, s2_vld_d;   // prod_q holds a product awaiting accumulation
  logic signed [PROD_W-1:0] mul_p;
  logic                     run;
  logic                     handshake;

  cnn_mac_mul_10s_14s u_mul (
    .a_i (bus.act_q0),
    .b_i (bus.w_q0),
    .p_o (mul_p)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    // A read issued in RUN returns data one cycle later. That data is
    // multiplied into prod_q, and the product is added to acc one cycle
    // after that.
    s1_vld_d = (state_q == S_RUN);
    s2_vld_d = s1_vld_q;
    prod_d   = s1_vld_q ? mul_p : prod_q;
    if (s2_vld_q) begin
      acc_d = acc_q + sext_prod(prod_q);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          acc_d   = bus.bias;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_TAP) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      // The counter is reused here to time the two pipeline-flush cycles.
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(1)) begin
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run       = (state_q == S_RUN);
  assign handshake = (state_q == S_OUT) && bus.out_ready;

  assign bus.act_ce0      = run;
  assign bus.w_ce0        = run;
  assign bus.act_address0 = run ? cnt_q : '0;
  assign bus.w_address0   = run ? cnt_q : '0;

  assign bus.ap_idle   = (state_q == S_IDLE);
  assign bus.ap_done   = handshake;
  assign bus.ap_ready  = handshake;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = ((RELU != 0) && acc_q[ACC_W-1]) ? '0 : acc_q;

endmodule

// File: tb/tb_cnn_conv_mac_ctrl.sv
// tb_cnn_conv_mac_ctrl
// Runs two controllers (RELU=1 and RELU=0, both NTAPS=9) in lockstep. Both
// are fed the same stimulus and served by identical registered-read memory
// models. Results are compared against hand-computed values.
module tb_cnn_conv_mac_ctrl;

  logic ap_clk;
  logic ap_rst;

  cnn_conv_mac_ctrl_if bus_r ();
  cnn_conv_mac_ctrl_if bus_n ();

  cnn_conv_mac_ctrl #(.NTAPS(9), .RELU(1)) u_dut_relu (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus_r)
  );

  cnn_conv_mac_ctrl #(.NTAPS(9), .RELU(0)) u_dut_raw (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus_n)
  );

  logic signed [9:0]  act_mem [16];
  logic signed [13:0] w_mem   [16];

  // Memory models: the read data appears one cycle after ce.
  always @(posedge ap_clk) begin
    if (bus_r.act_ce0) bus_r.act_q0 <= act_mem[bus_r.act_address0];
    if (bus_r.w_ce0)   bus_r.w_q0   <= w_mem[bus_r.w_address0];
    if (bus_n.act_ce0) bus_n.act_q0 <= act_mem[bus_n.act_address0];
    if (bus_n.w_ce0)   bus_n.w_q0   <= w_mem[bus_n.w_address0];
  end

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic signed [31:0] b, input logic rdy);
    bus_r.ap_start  = start;  bus_n.ap_start  = start;
    bus_r.bias      = b;      bus_n.bias      = b;
    bus_r.out_ready = rdy;    bus_n.out_ready = rdy;
  endtask

  task automatic set_mem(input int a0, input int astep, input int w);
    for (int i = 0; i < 16; i++) begin
      act_mem[i] = 10'(a0 + astep * i);
      w_mem[i]   = 14'(w);
    end
  endtask

  // Issues a one-cycle start. On return the bench is in cycle 1 after acceptance.
  task automatic start_op(input logic signed [31:0] b, input logic rdy);
    drive(1'b1, b, rdy);
    tick();
    drive(1'b0, b, rdy);
  endtask

  // Called in cycle 1 after acceptance. Returns the cycle number at which
  // out_valid is first seen; gives up after 40 cycles.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus_r.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int ndone;
  int nvalid;
  logic signed [31:0] got_data;

  initial begin
    set_mem(0, 0, 0);
    bus_r.act_q0 = '0; bus_r.w_q0 = '0;
    bus_n.act_q0 = '0; bus_n.w_q0 = '0;
    drive(1'b0, 0, 1'b0);
    ap_rst = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_idle",     32'(bus_r.ap_idle), 1);
    chk("rst_done",     32'(bus_r.ap_done), 0);
    chk("rst_ready",    32'(bus_r.ap_ready), 0);
    chk("rst_valid",    32'(bus_r.out_valid), 0);
    chk("rst_data",     bus_n.out_data, 0);
    chk("rst_act_ce",   32'(bus_r.act_ce0), 0);
    chk("rst_w_ce",     32'(bus_r.w_ce0), 0);
    chk("rst_act_addr", 32'(bus_r.act_address0), 0);
    chk("rst_w_addr",   32'(bus_r.w_address0), 0);
    ap_rst = 1'b0;
    tick();

    // T1: act=1..9, w=2, bias=0, out_ready=1. Expected 2*45 = 90 at cycle 12.
    set_mem(1, 1, 2);
    start_op(0, 1'b1);
    lat = 1;
    while (!bus_r.out_valid && lat < 40) begin
      if (lat == 1) begin
        chk("t1_ce_c1",   32'(bus_r.act_ce0), 1);
        chk("t1_addr_c1", 32'(bus_r.act_address0), 0);
      end
      if (lat == 9) begin
        chk("t1_wce_c9",   32'(bus_r.w_ce0), 1);
        chk("t1_waddr_c9", 32'(bus_r.w_address0), 8);
      end
      if (lat == 10) begin
        chk("t1_ce_c10",   32'(bus_r.act_ce0), 0);
        chk("t1_addr_c10", 32'(bus_r.act_address0), 0);
      end
      tick();
      lat++;
    end
    chk("t1_latency", lat, 12);
    chk("t1_data_relu", bus_r.out_data, 90);
    chk("t1_data_raw",  bus_n.out_data, 90);
    chk("t1_done",  32'(bus_r.ap_done), 1);
    chk("t1_ready", 32'(bus_r.ap_ready), 1);
    $display("txn t1: relu=%0d raw=%0d lat=%0d", bus_r.out_data, bus_n.out_data, lat);
    tick();
    chk("t1_idle_after", 32'(bus_r.ap_idle), 1);
    chk("t1_done_after", 32'(bus_r.ap_done), 0);

    // T2: act=-512, w=8191, bias=0. Each tap is -4,193,792; nine taps sum to -37,744,128.
    set_mem(-512, 0, 8191);
    start_op(0, 1'b1);
    wait_valid(lat);
    chk("t2_latency",   lat, 12);
    chk("t2_data_raw",  bus_n.out_data, -37744128);
    chk("t2_data_relu", bus_r.out_data, 0);
    $display("txn t2: relu=%0d raw=%0d lat=%0d", bus_r.out_data, bus_n.out_data, lat);
    tick();

    // T3: act=-3, w=5, bias=10. Accumulator is 10 - 135 = -125.
    set_mem(-3, 0, 5);
    start_op(10, 1'b1);
    wait_valid(lat);
    chk("t3_latency",   lat, 12);
    chk("t3_data_raw",  bus_n.out_data, -125);
    chk("t3_data_relu", bus_r.out_data, 0);
    $display("txn t3: relu=%0d raw=%0d lat=%0d", bus_r.out_data, bus_n.out_data, lat);
    tick();

    // T4: out_ready held low for 5 OUT cycles. act=1..9, w=3, bias=7 gives 142.
    set_mem(1, 1, 3);
    start_op(7, 1'b0);
    wait_valid(lat);
    chk("t4_latency", lat, 12);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(bus_r.out_valid), 1);
      chk("t4_hold_data",  bus_r.out_data, 142);
      chk("t4_hold_done",  32'(bus_r.ap_done), 0);
      tick();
    end
    drive(1'b0, 7, 1'b1);
    #1;
    chk("t4_rise_done",  32'(bus_r.ap_done), 1);
    chk("t4_rise_ready", 32'(bus_n.ap_ready), 1);
    chk("t4_rise_data",  bus_n.out_data, 142);
    $display("txn t4: relu=%0d raw=%0d lat=%0d", bus_r.out_data, bus_n.out_data, lat);
    tick();
    chk("t4_idle_after", 32'(bus_r.ap_idle), 1);

    // T5: ap_start pulsed during RUN with a different bias. The pulse must be
    // ignored, so there is exactly one done and the result is still 90.
    set_mem(1, 1, 2);
    start_op(0, 1'b1);
    ndone = 0;
    got_data = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus_r.ap_done) begin
        ndone++;
        got_data = bus_r.out_data;
      end
      drive((c == 3), 1000, 1'b1);
      tick();
    end
    chk("t5_done_count", ndone, 1);
    chk("t5_data", got_data, 90);
    $display("txn t5: data=%0d done_count=%0d", got_data, ndone);

    // T6: reset asserted at RUN cycle 4. The operation aborts and is never completed.
    start_op(0, 1'b1);
    tick(); tick(); tick();
    chk("t6_run_ce", 32'(bus_r.act_ce0), 1);
    ap_rst = 1'b1;
    #1;
    chk("t6_rst_idle",  32'(bus_r.ap_idle), 1);
    chk("t6_rst_ce",    32'(bus_r.act_ce0), 0);
    chk("t6_rst_valid", 32'(bus_n.out_valid), 0);
    chk("t6_rst_data",  bus_n.out_data, 0);
    tick();
    ap_rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_r.out_valid || bus_r.ap_done || bus_n.out_valid) nvalid++;
      tick();
    end
    chk("t6_no_valid", nvalid, 0);
    $display("txn t6: aborted, valid_count=%0d", nvalid);

    // T7: ap_start held high. The second start is accepted the cycle after
    // done and samples the new bias (-1000 + 90 = -910).
    drive(1'b1, 5, 1'b1);
    tick();
    wait_valid(lat);
    chk("t7a_latency", lat, 12);
    chk("t7a_data",    bus_r.out_data, 95);
    chk("t7a_done",    32'(bus_r.ap_done), 1);
    $display("txn t7a: relu=%0d raw=%0d lat=%0d", bus_r.out_data, bus_n.out_data, lat);
    drive(1'b1, -1000, 1'b1);
    tick();
    chk("t7_idle_gap", 32'(bus_r.ap_idle), 1);
    lat = 1;
    while (!bus_r.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("t7b_latency",  lat, 13);
    chk("t7b_data_raw", bus_n.out_data, -910);
    chk("t7b_data_relu", bus_r.out_data, 0);
    $display("txn t7b: relu=%0d raw=%0d lat=%0d", bus_r.out_data, bus_n.out_data, lat);
    drive(1'b0, 0, 1'b1);
    tick();
    tick();
    chk("t7_idle_end", 32'(bus_r.ap_idle), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
